aes_cipher: RTL and testbench
=============================

Name: aes_cipher

Overview:
- Byte-serial, AES-flavoured stream cipher.
- Encrypts one 8-bit byte per accepted input using the AES S-box and an 8-bit rolling round key. The round key is seeded per message and evolved AES-style with Rcon constants.
- Sits between a byte-wide producer and consumer.
- Fixed one-cycle registered latency; no back-pressure.

Parameters:
- NUM_RCON, 10, length of the Rcon sequence the round-key update cycles through.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset_n  input  1  reset; one clock, synchronous, active-high (asserted when 1, sampled on clk rising edge).
- valid_in  input  1  data_in holds a byte to encrypt this cycle.
- new_message  input  1  start of message; load key into the round-key register.
- key  input  8  message seed key; sampled only when new_message=1.
- data_in  input  8  plaintext byte.
- data_out  output  8  ciphertext byte (registered).
- valid_out  output  1  data_out valid this cycle (registered, one-cycle pulse per input byte).

Behaviour:
- Reset (reset_n=1 at edge):
  - data_out=0x00, valid_out=0.
  - round key K=0x00, Rcon index r=0.
  - Reset has priority over all inputs. A reset mid-message discards in-flight state; any pending output is not delivered.
- SBOX(x) is the standard FIPS-197 AES forward S-box, 256-entry combinational table.
- RCON[0..9] = 01,02,04,08,10,20,40,80,1B,36.
- new_message=1 (no reset): K<=key, r<=0.
- valid_in=1, new_message=0, at edge:
  - data_out<=SBOX(data_in XOR K), valid_out<=1.
  - K<=SBOX(K) XOR RCON[r].
  - r<=(r==NUM_RCON-1)?0:r+1 (wraps after 10 bytes).
- valid_in=1 and new_message=1 together:
  - The byte is encrypted with the incoming key port value (K_eff=key, r_eff=0).
  - data_out<=SBOX(data_in XOR key).
  - K<=SBOX(key) XOR RCON[0], r<=1.
- valid_in=0: valid_out<=0, data_out holds its last value, K and r unchanged.
- Latency: byte accepted at edge n appears with valid_out=1 after edge n, i.e. sampleable at edge n+1.
- Throughput: one byte per clock, unbounded back-to-back stream.
- valid_in before any new_message after reset uses K=0x00, r=0.
- new_message alone (valid_in=0) produces no output.
- Messages may be any length; Rcon keeps wrapping.
- Inputs are assumed stable around the clock edge; no internal synchronisers.

Optional Feature:
- Macro AES_CIPHER_CHAIN_EN.
- Defined:
  - Adds an 8-bit register P (previous ciphertext), cleared by reset and by new_message.
  - Output becomes SBOX(data_in XOR K XOR P); P<=that output on every accepted byte.
  - With simultaneous new_message, P is taken as 0x00.
- Undefined: no P register; output per Behaviour exactly.

Test Plan:
- Reset, then new_message with key=0x00, then data_in 0x00,0x00 on consecutive valid cycles -> outputs 0x63 then 0xAA (K goes 0x00 -> 0x62 -> 0xA8). Two valid_out pulses one cycle after each input.
- new_message key=0x52, then data_in=0x01 -> data_out=0xED. Then valid_in low -> valid_out=0 and data_out holds 0xED.
- new_message key=0x01 simultaneous with valid_in data_in=0x00 -> data_out=0x7C (incoming key used, not the old K).
- 10-byte message followed by an 11th byte, checked against a reference model -> Rcon index wraps to 0x01 on the 11th update. Also check 0x00 key with 0xFF data -> 0x16.
- Assert reset_n mid-stream for one cycle -> next edge valid_out=0, data_out=0x00. Byte then sent without new_message uses K=0x00: data_in 0x00 -> 0x63.
- With AES_CIPHER_CHAIN_EN: key 0x00, bytes 0x00,0x00 -> 0x63, then SBOX(0x62 XOR 0x63)=SBOX(0x01)=0x7C.

Source files
------------

// File: rtl/aes_cipher.sv
// aes_cipher: byte-serial AES-flavoured stream cipher, one-cycle latency.
// Define AES_CIPHER_CHAIN_EN to chain each ciphertext byte into the next.
module aes_cipher #(
  parameter int NUM_RCON = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       valid_in,
  input  logic       new_message,
  input  logic [7:0] key,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       valid_out
);

  localparam int RW = (NUM_RCON > 1) ? $clog2(NUM_RCON) : 1;
  localparam logic [RW-1:0] R_LAST = RW'(NUM_RCON - 1);

  // Entry 0x00 sits in the most significant byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [10:0] idx;
    idx = {~x, 3'b000};
    return SBOX_TBL[idx +: 8];
  endfunction

  // Rcon[i] is x^i in GF(2^8): 01,02,04,...,80,1b,36,...
  function automatic logic [7:0] rcon(input logic [RW-1:0] i);
    logic [7:0] v;
    v = 8'h01;
    for (int j = 0; j < NUM_RCON; j++) begin
      if (RW'(j) < i)
        v = {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    end
    return v;
  endfunction

  logic [7:0]    k_q;
  logic [RW-1:0] r_q;
  logic [7:0]    k_eff;
  logic [RW-1:0] r_eff;
  logic [7:0]    k_upd;
  logic [RW-1:0] r_upd;
  logic [7:0]    ct;

`ifdef AES_CIPHER_CHAIN_EN
  logic [7:0] p_q;
  logic [7:0] p_eff;
`endif

  // A new message overrides the stored key state for this byte.
  always_comb begin
    k_eff = new_message ? key : k_q;
    r_eff = new_message ? '0 : r_q;
`ifdef AES_CIPHER_CHAIN_EN
    p_eff = new_message ? 8'h00 : p_q;
    ct    = sbox(data_in ^ k_eff ^ p_eff);
`else
    ct    = sbox(data_in ^ k_eff);
`endif
    k_upd = sbox(k_eff) ^ rcon(r_eff);
    r_upd = (r_eff == R_LAST) ? '0 : r_eff + RW'(1);
  end

  // Output register and rolling key state.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      data_out  <= 8'h00;
      valid_out <= 1'b0;
      k_q       <= 8'h00;
      r_q       <= '0;
`ifdef AES_CIPHER_CHAIN_EN
      p_q       <= 8'h00;
`endif
    end else begin
      valid_out <= valid_in;
      if (valid_in) begin
        data_out <= ct;
        k_q      <= k_upd;
        r_q      <= r_upd;
`ifdef AES_CIPHER_CHAIN_EN
        p_q      <= ct;
`endif
      end else if (new_message) begin
        k_q      <= key;
        r_q      <= '0;
`ifdef AES_CIPHER_CHAIN_EN
        p_q      <= 8'h00;
`endif
      end
    end
  end

endmodule

// File: tb/tb_aes_cipher.sv
// tb_aes_cipher: scoreboard bench for aes_cipher.
// Expected bytes come from hand vectors or a GF(2^8)-derived S-box model.
module tb_aes_cipher;

  logic       clk;
  logic       reset_n;
  logic       valid_in;
  logic       new_message;
  logic [7:0] key;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       valid_out;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] bs[256];
  logic [7:0] rc[10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                         8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  logic [7:0] k_m, p_m;
  int         r_m;

  aes_cipher #(.NUM_RCON(10)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .valid_in(valid_in),
    .new_message(new_message),
    .key(key),
    .data_in(data_in),
    .data_out(data_out),
    .valid_out(valid_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] w;
    w = {b, b} << n;
    return w[15:8];
  endfunction

  // S-box from multiplicative inverse plus affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      bs[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3)
            ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  // One clock of stimulus; pushes the hand value or the model value.
  task automatic step(input bit v, input bit nm, input logic [7:0] k,
                      input logic [7:0] d, input bit hand,
                      input logic [7:0] hv);
    logic [7:0] ke, pe, e;
    int re;
    ke = nm ? k : k_m;
    re = nm ? 0 : r_m;
    pe = 8'h00;
`ifdef AES_CIPHER_CHAIN_EN
    pe = nm ? 8'h00 : p_m;
`endif
    e = bs[d ^ ke ^ pe];
    if (v) begin
      exp_q.push_back(hand ? hv : e);
      k_m = bs[ke] ^ rc[re];
      r_m = (re == 9) ? 0 : re + 1;
      p_m = e;
    end else if (nm) begin
      k_m = k;
      r_m = 0;
      p_m = 8'h00;
    end
    valid_in = v;
    new_message = nm;
    key = k;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic check(input string name, input logic [7:0] act,
                       input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%02h required=%02h", name, act, req);
    end
  endtask

  // Reset for one edge, optionally with a byte that must be dropped.
  task automatic do_reset(input bit v, input logic [7:0] d);
    reset_n = 1'b1;
    valid_in = v;
    new_message = 1'b0;
    key = 8'h00;
    data_in = d;
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    valid_in = 1'b0;
    k_m = 8'h00;
    r_m = 0;
    p_m = 8'h00;
    check("rst_valid", {7'd0, valid_out}, 8'h00);
    check("rst_data", data_out, 8'h00);
  endtask

  // Scoreboard monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (valid_out) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out actual=%02h required=none",
                 data_out);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (data_out !== e) begin
          errors++;
          $display("FAIL data_out actual=%02h required=%02h",
                   data_out, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b1;
    valid_in = 1'b0;
    new_message = 1'b0;
    key = 8'h00;
    data_in = 8'h00;
    k_m = 8'h00;
    r_m = 0;
    p_m = 8'h00;
    build_sbox();
    check("model_sbox00", bs[0], 8'h63);
    check("model_sboxff", bs[255], 8'h16);
    @(posedge clk);
    #1;
    do_reset(1'b0, 8'h00);

    step(1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 8'h63);
`ifdef AES_CIPHER_CHAIN_EN
    step(1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 8'h7c);
`else
    step(1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 8'haa);
`endif
    idle();
    check("pulse_end", {7'd0, valid_out}, 8'h00);

    step(1'b0, 1'b1, 8'h52, 8'h00, 1'b0, 8'h00);
    check("nm_no_out", {7'd0, valid_out}, 8'h00);
    step(1'b1, 1'b0, 8'h00, 8'h01, 1'b1, 8'hed);
    idle();
    check("hold_valid", {7'd0, valid_out}, 8'h00);
    check("hold_data", data_out, 8'hed);

    step(1'b1, 1'b1, 8'h01, 8'h00, 1'b1, 8'h7c);
    step(1'b1, 1'b1, 8'h00, 8'hff, 1'b1, 8'h16);
    idle();

    step(1'b0, 1'b1, 8'h2b, 8'h00, 1'b0, 8'h00);
    for (int i = 0; i < 11; i++)
      step(1'b1, 1'b0, 8'h00, 8'((i * 17) ^ 8'h5a), 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'h7e, 8'hc3, 1'b0, 8'h00);
    for (int i = 0; i < 12; i++)
      step(1'b1, 1'b0, 8'h00, 8'(i * 29), 1'b0, 8'h00);

    do_reset(1'b1, 8'h33);
    step(1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 8'h63);
    idle();
    idle();
    idle();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_out actual=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
